// File: rtl/cosine_controller_if.sv
// Control/status bundle between cosine_controller and its neighbours.
// The master side is the controller; the slave side is the datapath/system.
interface cosine_controller_if;
    logic        start;
    logic        done;
    logic [15:0] distance;
    logic [2:0]  state;
    logic [15:0] coefficient;
    logic        busy;
    logic        result_valid;
    logic        alert;
    logic        error;

    modport master (
        input  start, done, distance,
        output state, coefficient, busy,
        output result_valid, alert, error
    );

    modport slave (
        output start, done, distance,
        input  state, coefficient, busy,
        input  result_valid, alert, error
    );
endinterface

// File: rtl/cosine_controller.sv
// Sequencer for the cosine/distance datapath with Taylor coefficient ROM.
// Define COSINE_CTRL_ALERT_EN to build the proximity Alert state.
module cosine_controller #(
    parameter int          TERMS        = 5,
    parameter logic [15:0] THRESHOLD    = 16'h1000,
    parameter int          ALERT_CYCLES = 8,
    parameter int          DONE_TIMEOUT = 4
) (
    input logic               clk,
    input logic               rst_n,
    cosine_controller_if.master bus
);

    typedef enum logic [2:0] {
        StandBy      = 3'd0,
        Alert        = 3'd1,
        StartCalc    = 3'd2,
        Accumulate   = 3'd3,
        CalcDistance = 3'd4
    } state_t;

    localparam logic [2:0] TermsLast   = 3'(TERMS);
    localparam logic [7:0] TimeoutLast = 8'(DONE_TIMEOUT - 1);

    state_t      stateQ;
    logic [2:0]  k;
    logic [7:0]  waitCnt;
    logic [15:0] coefQ;
    logic        busyQ;
    logic        validQ;
    logic        alertQ;
    logic        errorQ;

`ifdef COSINE_CTRL_ALERT_EN
    localparam logic [7:0] AlertLast = 8'(ALERT_CYCLES - 1);
    logic [7:0] alertCnt;
`endif

    // -1/((2k-1)(2k)) in signed 5.11, rounded to nearest
    function automatic logic [15:0] coefRom(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd1:    c = 16'hFC00;
            3'd2:    c = 16'hFF55;
            3'd3:    c = 16'hFFBC;
            3'd4:    c = 16'hFFDB;
            3'd5:    c = 16'hFFE9;
            3'd6:    c = 16'hFFF0;
            default: c = 16'h0000;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ   <= StandBy;
            k        <= 3'd0;
            waitCnt  <= 8'd0;
            coefQ    <= 16'h0000;
            busyQ    <= 1'b0;
            validQ   <= 1'b0;
            alertQ   <= 1'b0;
            errorQ   <= 1'b0;
`ifdef COSINE_CTRL_ALERT_EN
            alertCnt <= 8'd0;
`endif
        end else begin
            validQ <= 1'b0;
            errorQ <= 1'b0;
            case (stateQ)
                StandBy: begin
                    if (bus.start) begin
                        stateQ <= StartCalc;
                        busyQ  <= 1'b1;
                        k      <= 3'd1;
                    end
                end
                StartCalc: begin
                    stateQ <= Accumulate;
                    coefQ  <= coefRom(k);
                end
                Accumulate: begin
                    if (k == TermsLast) begin
                        stateQ  <= CalcDistance;
                        coefQ   <= 16'h0000;
                        waitCnt <= 8'd0;
                    end else begin
                        k     <= k + 3'd1;
                        coefQ <= coefRom(k + 3'd1);
                    end
                end
                CalcDistance: begin
                    if (bus.done) begin
                        validQ <= 1'b1;
                        k      <= 3'd0;
`ifdef COSINE_CTRL_ALERT_EN
                        if (bus.distance < THRESHOLD) begin
                            stateQ   <= Alert;
                            alertQ   <= 1'b1;
                            alertCnt <= 8'd0;
                        end else begin
                            stateQ <= StandBy;
                            busyQ  <= 1'b0;
                        end
`else
                        stateQ <= StandBy;
                        busyQ  <= 1'b0;
`endif
                    end else if (waitCnt == TimeoutLast) begin
                        // datapath never answered: abandon the run
                        errorQ <= 1'b1;
                        k      <= 3'd0;
                        stateQ <= StandBy;
                        busyQ  <= 1'b0;
                    end else begin
                        waitCnt <= waitCnt + 8'd1;
                    end
                end
`ifdef COSINE_CTRL_ALERT_EN
                Alert: begin
                    if (alertCnt == AlertLast) begin
                        stateQ <= StandBy;
                        alertQ <= 1'b0;
                        busyQ  <= 1'b0;
                    end else begin
                        alertCnt <= alertCnt + 8'd1;
                    end
                end
`endif
                default: begin
                    stateQ <= StandBy;
                    coefQ  <= 16'h0000;
                    alertQ <= 1'b0;
                    busyQ  <= 1'b0;
                    k      <= 3'd0;
                end
            endcase
        end
    end

    assign bus.state        = stateQ;
    assign bus.coefficient  = coefQ;
    assign bus.busy         = busyQ;
    assign bus.result_valid = validQ;
    assign bus.alert        = alertQ;
    assign bus.error        = errorQ;

endmodule

// File: tb/tb_cosine_controller.sv
// Directed self-checking bench for cosine_controller.
// Expectations follow the build's COSINE_CTRL_ALERT_EN setting.
module tb_cosine_controller;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    cosine_controller_if bus ();

    cosine_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [15:0] coefTab [5];
    int n4;
    int nAlert;
    int nErr;
    int nValid;

    initial begin
        checks   = 0;
        failures = 0;
        coefTab  = '{16'hFC00, 16'hFF55, 16'hFFBC, 16'hFFDB, 16'hFFE9};

        // Reset with start asserted
        rst_n        = 1'b0;
        bus.start    = 1'b1;
        bus.done     = 1'b0;
        bus.distance = 16'h2000;
        tick();
        tick();
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_coef", 32'(bus.coefficient), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_valid", 32'(bus.result_valid), 32'd0);
        chk("rst_alert", 32'(bus.alert), 32'd0);
        chk("rst_error", 32'(bus.error), 32'd0);

        // Nominal run, distance above threshold
        rst_n = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("nom_s2", 32'(bus.state), 32'd2);
        chk("nom_busy", 32'(bus.busy), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("nom_s3", 32'(bus.state), 32'd3);
            chk("nom_coef", 32'(bus.coefficient), 32'(coefTab[i]));
        end
        tick();
        chk("nom_s4a", 32'(bus.state), 32'd4);
        chk("nom_coef0", 32'(bus.coefficient), 32'h0);
        tick();
        chk("nom_s4b", 32'(bus.state), 32'd4);
        chk("nom_valid_early", 32'(bus.result_valid), 32'd0);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        chk("nom_s0", 32'(bus.state), 32'd0);
        chk("nom_valid", 32'(bus.result_valid), 32'd1);
        chk("nom_alert", 32'(bus.alert), 32'd0);
        chk("nom_busy0", 32'(bus.busy), 32'd0);
        tick();
        chk("nom_valid_pulse", 32'(bus.result_valid), 32'd0);

        // Close-range run with start pulses during Accumulate and Alert
        bus.distance = 16'h0800;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("al_s2", 32'(bus.state), 32'd2);
        for (int i = 0; i < 5; i++) begin
            bus.start = (i == 2);
            tick();
            chk("al_s3", 32'(bus.state), 32'd3);
        end
        bus.start = 1'b0;
        tick();
        tick();
        chk("al_s4", 32'(bus.state), 32'd4);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        chk("al_valid", 32'(bus.result_valid), 32'd1);
`ifdef COSINE_CTRL_ALERT_EN
        chk("al_state1", 32'(bus.state), 32'd1);
`else
        chk("al_state0", 32'(bus.state), 32'd0);
`endif
        nAlert = bus.alert ? 1 : 0;
        nValid = 1;
        for (int i = 0; i < 20 && bus.state != 3'd0; i++) begin
            bus.start = (nAlert == 3);
            tick();
            bus.start = 1'b0;
            if (bus.alert) nAlert++;
            if (bus.result_valid) nValid++;
        end
`ifdef COSINE_CTRL_ALERT_EN
        chk("al_cycles", 32'(nAlert), 32'd8);
`else
        chk("al_cycles", 32'(nAlert), 32'd0);
`endif
        chk("al_end_state", 32'(bus.state), 32'd0);
        chk("al_alert_off", 32'(bus.alert), 32'd0);
        tick();
        chk("al_no_queue", 32'(bus.state), 32'd0);
        chk("al_valid_count", 32'(nValid), 32'd1);

        // Done timeout
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n4     = 0;
        nErr   = 0;
        nValid = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.state == 3'd4) n4++;
            if (bus.error) nErr++;
            if (bus.result_valid) nValid++;
            if (bus.state == 3'd0) break;
        end
        chk("to_s4_cycles", 32'(n4), 32'd4);
        chk("to_errors", 32'(nErr), 32'd1);
        chk("to_valid", 32'(nValid), 32'd0);
        chk("to_state", 32'(bus.state), 32'd0);
        tick();
        chk("to_err_pulse", 32'(bus.error), 32'd0);

        // Asynchronous reset in the third Accumulate cycle
        bus.distance = 16'h2000;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        chk("ar_coef3", 32'(bus.coefficient), 32'hFFBC);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_state", 32'(bus.state), 32'd0);
        chk("ar_coef", 32'(bus.coefficient), 32'h0);
        chk("ar_busy", 32'(bus.busy), 32'd0);
        #2;
        rst_n  = 1'b1;
        nValid = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.result_valid) nValid++;
        end
        chk("ar_no_valid", 32'(nValid), 32'd0);
        chk("ar_idle", 32'(bus.state), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
